// File: rtl/tinycomp_io_pkg.sv
// Shared constants and types for the TinyComp memory-mapped I/O controller.
package tinycomp_io_pkg;

    localparam logic [31:0] LED_ADDR  = 32'h0000_03FF;
    localparam logic [31:0] SW_ADDR   = 32'h0000_03FE;
    localparam logic [31:0] TMR_ADDR  = 32'h0000_03FD;
    localparam logic [31:0] CTRL_ADDR = 32'h0000_03FC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_CLR    = 2;

    localparam int unsigned RD_WAIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/tinycomp_io_if.sv
// CPU-side I/O strobe bundle: the CPU is the master, the I/O controller the slave.
interface tinycomp_io_if;

    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_wr;
    logic        io_rd;
    logic [31:0] io_rdata;
    logic        io_rdy;

    modport master (
        output io_addr, io_wdata, io_wr, io_rd,
        input  io_rdata, io_rdy
    );

    modport slave (
        input  io_addr, io_wdata, io_wr, io_rd,
        output io_rdata, io_rdy
    );

endinterface

// File: rtl/tinycomp_io_timer.sv
// Down-counting timer with optional auto-reload and a sticky expired flag.
module tinycomp_io_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    input  logic        auto_reload,
    input  logic        clr,
    output logic [31:0] count,
    output logic        expired
);

    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        expired_q, expired_d;
    logic        fired_q, fired_d;
    logic        expire;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        fired_d  = fired_q;
        expire   = 1'b0;
        if (load) begin
            // A load on the expiring edge wins and suppresses the expiry.
            count_d  = load_val;
            reload_d = load_val;
            fired_d  = 1'b0;
        end else if (en) begin
            if (count_q == 32'd1) begin
                expire  = 1'b1;
                fired_d = 1'b1;
                count_d = auto_reload ? reload_q : 32'd0;
            end else if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (!fired_q) begin
                // Enabled on an already-zero count: flag it exactly once until reloaded.
                expire  = 1'b1;
                fired_d = 1'b1;
            end
        end
        expired_d = expire | (expired_q & ~clr);
    end

    // NOTE: reset is sampled on the clock edge, and sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            fired_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
            fired_q   <= fired_d;
        end
    end

    assign count   = count_q;
    assign expired = expired_q;

endmodule

// File: rtl/tinycomp_io_ctrl.sv
// TinyComp I/O controller: address decode, LED/control registers, switch synchroniser
// and a wait-state read sequencer in front of the timer.
module tinycomp_io_ctrl
    import tinycomp_io_pkg::*;
#(
    parameter int unsigned RD_WAIT = RD_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    tinycomp_io_if.slave       bus,
    input  logic [7:0]         sw_in,
    output logic [7:0]         leds,
    output logic               tmr_expired
);

    logic [7:0]  leds_q, leds_d;
    logic        en_q, en_d;
    logic        auto_reload_q, auto_reload_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    rd_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wait_q, wait_d;
    logic        io_rdy_q, io_rdy_d;
    logic [31:0] io_rdata_q, io_rdata_d;
    logic [31:0] tmr_count;
    logic [31:0] rd_mux;
    logic        wr_led, wr_tmr, wr_ctrl;

    assign wr_led  = bus.io_wr && (bus.io_addr == LED_ADDR);
    assign wr_tmr  = bus.io_wr && (bus.io_addr == TMR_ADDR);
    assign wr_ctrl = bus.io_wr && (bus.io_addr == CTRL_ADDR);

    tinycomp_io_timer u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (wr_tmr),
        .load_val    (bus.io_wdata),
        .en          (en_q),
        .auto_reload (auto_reload_q),
        .clr         (wr_ctrl && bus.io_wdata[CTRL_CLR]),
        .count       (tmr_count),
        .expired     (tmr_expired)
    );

    always_comb begin
        leds_d        = wr_led  ? bus.io_wdata[7:0]           : leds_q;
        en_d          = wr_ctrl ? bus.io_wdata[CTRL_EN]       : en_q;
        auto_reload_d = wr_ctrl ? bus.io_wdata[CTRL_RELOAD]   : auto_reload_q;
    end

    always_comb begin
        case (addr_q)
            LED_ADDR:  rd_mux = {24'b0, leds_q};
            SW_ADDR:   rd_mux = {24'b0, sw_sync_q};
            TMR_ADDR:  rd_mux = tmr_count;
            CTRL_ADDR: rd_mux = {29'b0, tmr_expired, auto_reload_q, en_q};
            default:   rd_mux = 32'b0;
        endcase
    end

    // Read FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.io_rd) state_d = WAIT;
            WAIT:    if (!bus.io_rd) state_d = IDLE;
                     else if (wait_q == 4'd0) state_d = DONE;
            DONE:    if (!bus.io_rd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM: datapath and registered outputs.
    always_comb begin
        addr_d     = addr_q;
        wait_d     = wait_q;
        io_rdy_d   = io_rdy_q;
        io_rdata_d = io_rdata_q;
        case (state_q)
            IDLE: if (bus.io_rd) begin
                addr_d = bus.io_addr;
                wait_d = 4'(RD_WAIT - 1);
            end
            WAIT: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                if (state_d == DONE) io_rdata_d = rd_mux;
            end
            DONE: begin
                io_rdy_d = bus.io_rd;
                if (!bus.io_rd) io_rdata_d = 32'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds_q        <= '0;
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            state_q       <= IDLE;
            addr_q        <= '0;
            wait_q        <= '0;
            io_rdy_q      <= 1'b0;
            io_rdata_q    <= '0;
        end else begin
            leds_q        <= leds_d;
            en_q          <= en_d;
            auto_reload_q <= auto_reload_d;
            sw_meta_q     <= sw_in;
            sw_sync_q     <= sw_meta_q;
            state_q       <= state_d;
            addr_q        <= addr_d;
            wait_q        <= wait_d;
            io_rdy_q      <= io_rdy_d;
            io_rdata_q    <= io_rdata_d;
        end
    end

    assign leds         = leds_q;
    assign bus.io_rdy   = io_rdy_q;
    assign bus.io_rdata = io_rdata_q;

endmodule
